// File: rtl/clkswitch_pkg.sv
// Shared types and default timing for the clock-switch select sequencer.
package clkswitch_pkg;

    typedef enum logic [1:0] {
        ON_A      = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        ON_B      = 2'd3
    } state_t;

    localparam int unsigned DEF_LOCK_CYCLES    = 256;
    localparam int unsigned DEF_SETTLE_CYCLES  = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;

endpackage

// File: rtl/clkswitch_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module sync2 (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/clkswitch_ctrl.sv
// Select sequencer for the dynamic clock switch: moves between reference clock A
// and PLL clock B, gated on stable lock, with a hold-off after every select change.
module clkswitch_ctrl
    import clkswitch_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_req,
    input  logic i_pll_lock,
    input  logic i_fault_clr,
    output logic o_sel,
    output logic o_busy,
    output logic o_done,
    output logic o_fault
);

    localparam int unsigned LW = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES)    : 1;
    localparam int unsigned SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0] ST_MAX   = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    logic          req_s;
    logic          lock_s;
    state_t        state;
    logic          target_b;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] st_cnt;
    logic [TW-1:0] to_cnt;

    sync2 u_sync_req (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_d        (i_req),
        .o_q        (req_s)
    );

    sync2 u_sync_lock (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_d        (i_pll_lock),
        .o_q        (lock_s)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state    <= ON_A;
            target_b <= 1'b0;
            lock_cnt <= '0;
            st_cnt   <= '0;
            to_cnt   <= '0;
            o_sel    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_fault  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // Clear first so any fault set later in this cycle takes precedence.
            if (i_fault_clr) begin
                o_fault <= 1'b0;
            end

            unique case (state)
                ON_A: begin
                    if (req_s && !o_fault) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                        to_cnt   <= '0;
                        o_busy   <= 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    to_cnt   <= to_cnt + 1'b1;
                    lock_cnt <= lock_s ? lock_cnt + 1'b1 : '0;
                    if (!req_s) begin
                        state  <= ON_A;
                        o_busy <= 1'b0;
                    end else if (lock_s && lock_cnt == LOCK_MAX) begin
                        state    <= SETTLE;
                        st_cnt   <= '0;
                        target_b <= 1'b1;
                        o_sel    <= 1'b1;
                    end else if (to_cnt == TO_MAX) begin
                        state   <= ON_A;
                        o_fault <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (st_cnt == ST_MAX) begin
                        state  <= target_b ? ON_B : ON_A;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end

                ON_B: begin
                    if (!lock_s || !req_s) begin
                        state    <= SETTLE;
                        st_cnt   <= '0;
                        target_b <= 1'b0;
                        o_sel    <= 1'b0;
                        o_busy   <= 1'b1;
                        if (!lock_s) begin
                            o_fault <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ON_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkswitch_ctrl.sv
// Directed bench for clkswitch_ctrl with LOCK=8, SETTLE=4, TIMEOUT=32.
module tb_clkswitch_ctrl;
    import clkswitch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic lock;
    logic fclr;
    logic sel;
    logic busy;
    logic done;
    logic fault;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    clkswitch_ctrl #(
        .LOCK_CYCLES    (8),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .i_clk       (clk),
        .i_areset_n  (rst_n),
        .i_req       (req),
        .i_pll_lock  (lock),
        .i_fault_clr (fclr),
        .o_sel       (sel),
        .o_busy      (busy),
        .o_done      (done),
        .o_fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        lock  = 1'b1;
        fclr  = 1'b0;
        #3;
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", 32'(dut.state), 32'(ON_A));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle_sel", sel, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_fault", fault, 0);
            chk("idle_state", 32'(dut.state), 32'(ON_A));
        end

        // Clean switch to B (edge 0 = the tick after which req rises)
        tick(1); req = 1'b1;
        tick(2); chk("clean_busy_e2", busy, 0);
        tick(1); chk("clean_busy_e3", busy, 1);
        chk("clean_state_e3", 32'(dut.state), 32'(WAIT_LOCK));
        tick(7); chk("clean_sel_e10", sel, 0);
        tick(1); chk("clean_sel_e11", sel, 1);
        chk("clean_state_e11", 32'(dut.state), 32'(SETTLE));
        tick(3); chk("clean_done_e14", done, 0);
        chk("clean_busy_e14", busy, 1);
        tick(1); chk("clean_done_e15", done, 1);
        chk("clean_busy_e15", busy, 0);
        chk("clean_state_e15", 32'(dut.state), 32'(ON_B));
        tick(1); chk("clean_done_e16", done, 0);
        chk("clean_sel_e16", sel, 1);

        // Request back to A, no fault
        req = 1'b0;
        tick(3); chk("back_sel_e3", sel, 0);
        chk("back_busy_e3", busy, 1);
        chk("back_fault_e3", fault, 0);
        tick(4); chk("back_done_e7", done, 1);
        chk("back_state_e7", 32'(dut.state), 32'(ON_A));

        // Lock glitch during WAIT_LOCK
        tick(1); req = 1'b1;
        tick(5); lock = 1'b0;
        tick(1); lock = 1'b1;
        tick(5); chk("glitch_sel_e11", sel, 0);
        tick(4); chk("glitch_sel_e15", sel, 0);
        tick(1); chk("glitch_sel_e16", sel, 1);
        tick(4); chk("glitch_done_e20", done, 1);
        chk("glitch_state_e20", 32'(dut.state), 32'(ON_B));

        // Lock loss on B with coincident fault clear
        tick(1); lock = 1'b0;
        tick(2); chk("loss_sel_e2", sel, 1);
        chk("loss_fault_e2", fault, 0);
        fclr = 1'b1;
        tick(1); fclr = 1'b0;
        chk("loss_sel_e3", sel, 0);
        chk("loss_fault_e3", fault, 1);
        chk("loss_busy_e3", busy, 1);
        tick(3); chk("loss_done_e6", done, 0);
        tick(1); chk("loss_done_e7", done, 1);
        chk("loss_state_e7", 32'(dut.state), 32'(ON_A));
        tick(1); chk("loss_done_e8", done, 0);
        chk("loss_fault_e8", fault, 1);
        tick(5); chk("loss_ignore_busy", busy, 0);
        chk("loss_ignore_state", 32'(dut.state), 32'(ON_A));
        req = 1'b0;
        tick(3); fclr = 1'b1;
        tick(1); fclr = 1'b0;
        chk("loss_clr_fault", fault, 0);
        tick(4); chk("loss_clr_state", 32'(dut.state), 32'(ON_A));

        // Lock timeout (lock held low)
        tick(1); req = 1'b1;
        tick(34); chk("to_fault_e34", fault, 0);
        chk("to_busy_e34", busy, 1);
        tick(1); chk("to_fault_e35", fault, 1);
        chk("to_busy_e35", busy, 0);
        chk("to_state_e35", 32'(dut.state), 32'(ON_A));
        tick(10); chk("to_ignore_busy", busy, 0);
        chk("to_ignore_state", 32'(dut.state), 32'(ON_A));
        tick(1); fclr = 1'b1;
        tick(1); fclr = 1'b0;
        chk("to_clr_fault", fault, 0);
        tick(1); chk("to_rewait_busy", busy, 1);
        chk("to_rewait_state", 32'(dut.state), 32'(WAIT_LOCK));
        req = 1'b0;
        tick(3); chk("to_abort_state", 32'(dut.state), 32'(ON_A));
        chk("to_abort_busy", busy, 0);
        chk("to_abort_fault", fault, 0);

        // Async reset mid-SETTLE toward B
        lock = 1'b1;
        tick(5);
        tick(1); req = 1'b1;
        tick(12); chk("ar_sel_e12", sel, 1);
        chk("ar_state_e12", 32'(dut.state), 32'(SETTLE));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sel_async", sel, 0);
        chk("ar_busy_async", busy, 0);
        chk("ar_state_async", 32'(dut.state), 32'(ON_A));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1); chk("ar_state_rel", 32'(dut.state), 32'(ON_A));
        chk("ar_sel_rel", sel, 0);
        tick(3); chk("ar_state_idle", 32'(dut.state), 32'(ON_A));
        chk("ar_busy_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
